// File: rtl/digital_clock_dp.sv
// Digital clock datapath: loads time/alarm from a shared bus, counts hh:mm:ss
// from a prescaled clock, and drives an alarm FSM that raises ring on a match.
module digital_clock_dp #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned ALARM_LEN     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on,
  input  logic       ld_hr,
  input  logic       ld_min,
  input  logic       ld_sec,
  input  logic       ld_alarm_hr,
  input  logic       ld_alarm_min,
  input  logic       ld_alarm_sec,
  input  logic [5:0] data_in,
  input  logic       alarm_stop,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic       alarm_armed,
  output logic       ring,
  output logic       load_err
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam int unsigned CW = $clog2(ALARM_LEN + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] RING_INIT  = CW'(ALARM_LEN);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING} alarm_state_t;

  alarm_state_t  state;
  logic [PW-1:0] presc;
  logic [CW-1:0] ring_cnt;
  logic [4:0]    al_hr;
  logic [5:0]    al_min, al_sec;
  logic          match_q, match_d, alarm_loaded;

  logic tick, hr_ok, ms_ok, any_ld, any_acc, match_c;
  logic sel_min, sel_sec, sel_ahr, sel_amin, sel_asec;
  logic acc_hr, acc_min, acc_sec, acc_ahr, acc_amin, acc_asec;
  logic [4:0] hr_nx;
  logic [5:0] min_nx, sec_nx;

  always_comb begin
    tick     = on && (presc == PRESC_LAST);
    hr_ok    = (data_in <= 6'd23);
    ms_ok    = (data_in <= 6'd59);
    sel_min  = !ld_hr && ld_min;
    sel_sec  = !ld_hr && !ld_min && ld_sec;
    sel_ahr  = !(ld_hr || ld_min || ld_sec) && ld_alarm_hr;
    sel_amin = !(ld_hr || ld_min || ld_sec || ld_alarm_hr) && ld_alarm_min;
    sel_asec = !(ld_hr || ld_min || ld_sec || ld_alarm_hr || ld_alarm_min) && ld_alarm_sec;
    acc_hr   = ld_hr && hr_ok;
    acc_min  = sel_min && ms_ok;
    acc_sec  = sel_sec && ms_ok;
    acc_ahr  = sel_ahr && hr_ok;
    acc_amin = sel_amin && ms_ok;
    acc_asec = sel_asec && ms_ok;
    any_ld   = ld_hr || ld_min || ld_sec || ld_alarm_hr || ld_alarm_min || ld_alarm_sec;
    any_acc  = acc_hr || acc_min || acc_sec || acc_ahr || acc_amin || acc_asec;
    match_c  = (hr == al_hr) && (min == al_min) && (sec == al_sec);
  end

  // Tick increment first, then an accepted load overrides just its own field.
  always_comb begin
    hr_nx  = hr;
    min_nx = min;
    sec_nx = sec;
    if (tick) begin
      sec_nx = (sec == 6'd59) ? '0 : sec + 6'd1;
      if (sec == 6'd59) begin
        min_nx = (min == 6'd59) ? '0 : min + 6'd1;
        if (min == 6'd59)
          hr_nx = (hr == 5'd23) ? '0 : hr + 5'd1;
      end
    end
    if (acc_hr)  hr_nx  = data_in[4:0];
    if (acc_min) min_nx = data_in;
    if (acc_sec) sec_nx = data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      load_err <= 1'b0;
      hr       <= '0;
      min      <= '0;
      sec      <= '0;
      al_hr    <= '0;
      al_min   <= '0;
      al_sec   <= '0;
    end else begin
      if (!on || tick || acc_sec)
        presc <= '0;
      else
        presc <= presc + PW'(1);
      sec_tick <= tick;
      load_err <= any_ld && !any_acc;
      hr       <= hr_nx;
      min      <= min_nx;
      sec      <= sec_nx;
      if (acc_ahr)  al_hr  <= data_in[4:0];
      if (acc_amin) al_min <= data_in;
      if (acc_asec) al_sec <= data_in;
    end
  end

  // After an alarm load, the delayed match copy is resynced to the new compare
  // so an alarm loaded equal to the current time does not look like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q      <= 1'b0;
      match_d      <= 1'b0;
      alarm_loaded <= 1'b0;
    end else begin
      match_q      <= match_c;
      match_d      <= alarm_loaded ? match_c : match_q;
      alarm_loaded <= acc_ahr || acc_amin || acc_asec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ring_cnt    <= '0;
      alarm_armed <= 1'b0;
      ring        <= 1'b0;
    end else if (acc_ahr || acc_amin) begin
      state       <= IDLE;
      ring_cnt    <= '0;
      alarm_armed <= 1'b0;
      ring        <= 1'b0;
    end else if (acc_asec) begin
      state       <= ARMED;
      ring_cnt    <= '0;
      alarm_armed <= 1'b1;
      ring        <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (on && match_q && !match_d) begin
            state    <= RINGING;
            ring_cnt <= RING_INIT;
            ring     <= 1'b1;
          end
        end
        RINGING: begin
          if (!on || alarm_stop || (tick && ring_cnt == CW'(1))) begin
            state    <= ARMED;
            ring_cnt <= '0;
            ring     <= 1'b0;
          end else if (tick) begin
            ring_cnt <= ring_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_clock_dp.sv
// Directed-vector bench for digital_clock_dp with TICKS_PER_SEC=4, ALARM_LEN=3.
module tb_digital_clock_dp;

  logic       clk = 1'b0;
  logic       reset;
  logic       on;
  logic       ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec;
  logic [5:0] data_in;
  logic       alarm_stop;
  logic [4:0] hr;
  logic [5:0] min, sec;
  logic       sec_tick, alarm_armed, ring, load_err;

  int n_cmp = 0;
  int n_bad = 0;

  digital_clock_dp #(.TICKS_PER_SEC(4), .ALARM_LEN(3)) dut (
    .clk(clk), .reset(reset), .on(on),
    .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
    .ld_alarm_hr(ld_alarm_hr), .ld_alarm_min(ld_alarm_min), .ld_alarm_sec(ld_alarm_sec),
    .data_in(data_in), .alarm_stop(alarm_stop),
    .hr(hr), .min(min), .sec(sec), .sec_tick(sec_tick),
    .alarm_armed(alarm_armed), .ring(ring), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // strb order: {ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec}
  typedef struct {
    logic [5:0] strb;
    logic [5:0] data;
    logic [4:0] e_hr;
    logic [5:0] e_min;
    logic [5:0] e_sec;
    logic       e_armed;
    logic       e_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [5:0] s, input logic [5:0] d, input logic [4:0] h,
                              input logic [5:0] m, input logic [5:0] sc, input logic a,
                              input logic e);
    vec_t v;
    v.strb = s; v.data = d; v.e_hr = h; v.e_min = m; v.e_sec = sc;
    v.e_armed = a; v.e_err = e;
    return v;
  endfunction

  function automatic logic [31:0] obs();
    return {11'd0, hr, min, sec, sec_tick, alarm_armed, ring, load_err};
  endfunction

  function automatic logic [31:0] tm(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    return {15'd0, h, m, s};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_strb();
    {ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec} = '0;
  endtask

  task automatic ld(input int k, input logic [5:0] v);
    data_in = v;
    case (k)
      0: ld_hr = 1'b1;
      1: ld_min = 1'b1;
      2: ld_sec = 1'b1;
      3: ld_alarm_hr = 1'b1;
      4: ld_alarm_min = 1'b1;
      default: ld_alarm_sec = 1'b1;
    endcase
    step();
    clr_strb();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; on = 1'b0; alarm_stop = 1'b0; data_in = '0;
    clr_strb();

    vecs[0]  = mk(6'b000000,  0,  0,  0,  0, 0, 0);
    vecs[1]  = mk(6'b100000, 12, 12,  0,  0, 0, 0);
    vecs[2]  = mk(6'b010000, 34, 12, 34,  0, 0, 0);
    vecs[3]  = mk(6'b001000, 56, 12, 34, 56, 0, 0);
    vecs[4]  = mk(6'b100000, 24, 12, 34, 56, 0, 1);
    vecs[5]  = mk(6'b000000,  0, 12, 34, 56, 0, 0);
    vecs[6]  = mk(6'b010000, 60, 12, 34, 56, 0, 1);
    vecs[7]  = mk(6'b001000, 59, 12, 34, 59, 0, 0);
    vecs[8]  = mk(6'b110000,  5,  5, 34, 59, 0, 0);
    vecs[9]  = mk(6'b011000,  7,  5,  7, 59, 0, 0);
    vecs[10] = mk(6'b100000, 23, 23,  7, 59, 0, 0);
    vecs[11] = mk(6'b100000, 31, 23,  7, 59, 0, 1);
    vecs[12] = mk(6'b000001,  0, 23,  7, 59, 1, 0);
    vecs[13] = mk(6'b000100, 24, 23,  7, 59, 1, 1);
    vecs[14] = mk(6'b000010, 10, 23,  7, 59, 0, 0);
    vecs[15] = mk(6'b000001, 60, 23,  7, 59, 0, 1);
    vecs[16] = mk(6'b000001, 59, 23,  7, 59, 1, 0);
    vecs[17] = mk(6'b001100,  3, 23,  7,  3, 1, 0);
    vecs[18] = mk(6'b010000, 59, 23, 59,  3, 1, 0);

    step();
    chk("reset_state", obs(), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      {ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec} = vecs[i].strb;
      data_in = vecs[i].data;
      step();
      clr_strb();
      chk($sformatf("vec%0d", i), obs(),
          {11'd0, vecs[i].e_hr, vecs[i].e_min, vecs[i].e_sec, 1'b0, vecs[i].e_armed, 1'b0, vecs[i].e_err});
    end

    // Load and count
    do_reset();
    ld(0, 12); ld(1, 34); ld(2, 56);
    chk("load_time", tm(hr, min, sec), tm(12, 34, 56));
    on = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("count_k%0d", k), {24'd0, sec, 1'b0, sec_tick},
          {24'd0, 6'(56 + k / 4), 1'b0, 1'((k % 4) == 0)});
    end

    // Rollover
    on = 1'b0;
    ld(0, 23); ld(1, 59); ld(2, 59);
    on = 1'b1;
    repeat (4) step();
    chk("roll_day", tm(hr, min, sec), tm(0, 0, 0));
    on = 1'b0;
    ld(0, 10); ld(1, 59); ld(2, 59);
    on = 1'b1;
    repeat (4) step();
    chk("roll_hour", tm(hr, min, sec), tm(11, 0, 0));

    // Alarm fire and timeout
    on = 1'b0;
    do_reset();
    ld(3, 0); ld(4, 0); ld(5, 2);
    chk("armed_after_load", {31'd0, alarm_armed}, 32'd1);
    ld(0, 0); ld(1, 0); ld(2, 0);
    on = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 8) chk("sec_reaches_2", {26'd0, sec}, 32'd2);
      chk($sformatf("ring_k%0d", k), {31'd0, ring}, {31'd0, 1'((k >= 10) && (k <= 19))});
    end
    chk("armed_after_timeout", {31'd0, alarm_armed}, 32'd1);

    // Stop and disarm
    on = 1'b0;
    ld(2, 0);
    on = 1'b1;
    repeat (10) step();
    chk("ring_again", {31'd0, ring}, 32'd1);
    alarm_stop = 1'b1;
    step();
    alarm_stop = 1'b0;
    chk("stop_ring_armed", {30'd0, ring, alarm_armed}, 32'b01);
    ld(4, 0);
    chk("disarm", {31'd0, alarm_armed}, 32'd0);
    on = 1'b0;
    ld(2, 0);
    on = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k >= 9 && k <= 12) chk($sformatf("no_ring_k%0d", k), {31'd0, ring}, 32'd0);
    end

    // Async reset during ring
    on = 1'b0;
    do_reset();
    ld(5, 2);
    on = 1'b1;
    repeat (10) step();
    chk("ring_before_reset", {31'd0, ring}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", obs(), 32'd0);
    step();
    reset = 1'b0;

    // Load/tick collision, then mid-second ld_sec restarting the prescaler
    for (int k = 1; k <= 14; k++) begin
      if (k == 4)  ld_sec = 1'b1;
      if (k == 4)  data_in = 30;
      if (k == 10) ld_sec = 1'b1;
      if (k == 10) data_in = 10;
      step();
      clr_strb();
      if (k >= 4)
        chk($sformatf("collide_k%0d", k), {24'd0, sec, 1'b0, sec_tick},
            {24'd0, (k < 8) ? 6'd30 : (k < 10) ? 6'd31 : (k < 14) ? 6'd10 : 6'd11,
             1'b0, 1'((k == 4) || (k == 8) || (k == 14))});
    end
    chk("collide_hm", tm(hr, min, 0), tm(0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
